// File: rtl/key_code_decoder_10_to_4.sv
// key_code_decoder_10_to_4
//
// Receive-side decoder for the 10-to-4 active-low keypad priority encoder.
// The asynchronous 4-bit code from the encoder pins is synchronized and
// debounced. It is then expanded back into a 9-line active-low one-hot bus
// that follows the held key. Each debounced press is also reported once,
// as a value 1..9, through a single-entry valid/ready slot.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable synchronized samples needed to confirm
//                    a press or a release (1..65535)
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   Y_n      in   4  active-low code {Y3_n,Y2_n,Y1_n,Y0_n}; 4'b1111 = no key
//   D_n      out  9  active-low one-hot of the held key (bit k <-> Ak_n)
//   key_val  out  4  reported key value 1..9
//   key_vld  out  1  key_val valid, held until accepted
//   key_rdy  in   1  consumer accepts when key_vld & key_rdy
//   err      out  1  one-cycle pulse: an illegal code was confirmed
//   ovr      out  1  one-cycle pulse: a confirmed press was dropped (slot full)

module key_code_decoder_10_to_4 #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Y_n,
  output logic [8:0] D_n,
  output logic [3:0] key_val,
  output logic       key_vld,
  input  logic       key_rdy,
  output logic       err,
  output logic       ovr
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  NO_KEY   = 4'b1111;
  localparam logic [8:0]  ALL_OFF  = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  sync_p0;
  logic [3:0]  sync_p1;
  logic [3:0]  code;
  logic [3:0]  cand;
  logic [3:0]  cand_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [8:0]  d_n_nxt;
  logic [3:0]  key_val_nxt;
  logic        key_vld_nxt;
  logic        err_nxt;
  logic        ovr_nxt;
  logic        confirm;
  logic [3:0]  v_cand;
  logic        accept;
  logic        slot_free;

  // Active-low one-hot for key value v: key v lives on line 9-v.
  function automatic logic [8:0] onehot_low(input logic [3:0] v);
    logic [3:0] k;
    k = 4'd9 - v;
    return ~(9'd1 << k);
  endfunction

  // Only values 1..9 are produced by a healthy encoder; 0 means idle.
  function automatic logic is_legal(input logic [3:0] v);
    return (v != 4'd0) && (v <= 4'd9);
  endfunction

  // Stage p0/p1: two-flop synchronizer on the asynchronous encoder pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= NO_KEY;
      sync_p1 <= NO_KEY;
    end else begin
      sync_p0 <= Y_n;
      sync_p1 <= sync_p0;
    end
  end

  assign code      = sync_p1;
  assign v_cand    = ~cand;
  assign accept    = key_vld & key_rdy;
  // An acceptance in the same cycle frees the slot for a new confirm.
  assign slot_free = ~key_vld | accept;

  // Debounce state machine and output-slot update.
  always_comb begin
    state_nxt   = state;
    cand_nxt    = cand;
    cnt_nxt     = cnt;
    d_n_nxt     = D_n;
    key_val_nxt = key_val;
    key_vld_nxt = key_vld & ~key_rdy;
    err_nxt     = 1'b0;
    ovr_nxt     = 1'b0;
    confirm     = 1'b0;

    case (state)
      IDLE: begin
        if (code != NO_KEY) begin
          cand_nxt  = code;
          cnt_nxt   = 16'd0;
          state_nxt = DEB;
        end
      end

      DEB: begin
        if (code == cand) begin
          if (cnt == CNT_LAST) begin
            confirm   = 1'b1;
            state_nxt = HELD;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end else if (code == NO_KEY) begin
          state_nxt = IDLE;
        end else begin
          cand_nxt = code;
          cnt_nxt  = 16'd0;
        end
      end

      HELD: begin
        if (code == NO_KEY) begin
          cnt_nxt   = 16'd0;
          state_nxt = REL;
        end else if (code != cand) begin
          // Roll-over to a different key: debounce it as a fresh press.
          cand_nxt  = code;
          cnt_nxt   = 16'd0;
          state_nxt = DEB;
        end
      end

      REL: begin
        if (code == NO_KEY) begin
          if (cnt == CNT_LAST) begin
            d_n_nxt   = ALL_OFF;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end else if (code == cand) begin
          // The release was only a bounce of the same key.
          state_nxt = HELD;
        end else begin
          d_n_nxt   = ALL_OFF;
          cand_nxt  = code;
          cnt_nxt   = 16'd0;
          state_nxt = DEB;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (confirm) begin
      if (is_legal(v_cand)) begin
        // The bus always follows the held key, even if the report is dropped.
        d_n_nxt = onehot_low(v_cand);
        if (slot_free) begin
          key_val_nxt = v_cand;
          key_vld_nxt = 1'b1;
        end else begin
          ovr_nxt = 1'b1;
        end
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  // Stage p2: registered control state and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cand    <= NO_KEY;
      cnt     <= 16'd0;
      D_n     <= ALL_OFF;
      key_val <= 4'd0;
      key_vld <= 1'b0;
      err     <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cand    <= cand_nxt;
      cnt     <= cnt_nxt;
      D_n     <= d_n_nxt;
      key_val <= key_val_nxt;
      key_vld <= key_vld_nxt;
      err     <= err_nxt;
      ovr     <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_key_code_decoder_10_to_4.sv
// Testbench for key_code_decoder_10_to_4 (default DEBOUNCE_CYCLES = 4).
// Expected reports are queued when a press is driven and compared when the
// consumer accepts them; timing and side outputs are checked directly.

module tb_key_code_decoder_10_to_4;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic [3:0] Y_n;
  logic [8:0] D_n;
  logic [3:0] key_val;
  logic       key_vld;
  logic       key_rdy;
  logic       err;
  logic       ovr;

  int checks;
  int errors;
  logic [3:0] sb_q[$];

  key_code_decoder_10_to_4 #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .Y_n    (Y_n),
    .D_n    (D_n),
    .key_val(key_val),
    .key_vld(key_vld),
    .key_rdy(key_rdy),
    .err    (err),
    .ovr    (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every acceptance must match the oldest expected report.
  always @(negedge clk) begin
    if (!rst && key_vld && key_rdy) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_report", {28'd0, key_val}, 32'hF);
      end else begin
        chk("sb_key_val", {28'd0, key_val}, {28'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    clk_en  = 1'b0;
    rst     = 1'b0;
    Y_n     = 4'b1111;
    key_rdy = 1'b0;

    // 1. Reset with the clock stopped.
    #3 rst = 1'b1;
    #2;
    chk("rst_D_n", {23'd0, D_n}, 32'h1FF);
    chk("rst_key_val", {28'd0, key_val}, 32'd0);
    chk("rst_key_vld", {31'd0, key_vld}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ovr", {31'd0, ovr}, 32'd0);
    #3 rst = 1'b0;
    clk_en = 1'b1;
    tick(3);

    // 2. Press and hold key 9, acknowledge, release.
    Y_n = 4'b0110;
    sb_q.push_back(4'd9);
    tick(6);
    chk("p9_vld_e6", {31'd0, key_vld}, 32'd0);
    chk("p9_D_n_e6", {23'd0, D_n}, 32'h1FF);
    tick(1);
    chk("p9_vld_e7", {31'd0, key_vld}, 32'd1);
    chk("p9_val_e7", {28'd0, key_val}, 32'd9);
    chk("p9_D_n_e7", {23'd0, D_n}, 32'h1FE);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("p9_hold_vld", {31'd0, key_vld}, 32'd1);
      chk("p9_hold_val", {28'd0, key_val}, 32'd9);
    end
    key_rdy = 1'b1;
    tick(1);
    key_rdy = 1'b0;
    chk("p9_ack_vld", {31'd0, key_vld}, 32'd0);
    chk("p9_ack_D_n", {23'd0, D_n}, 32'h1FE);
    Y_n = 4'b1111;
    tick(6);
    chk("p9_rel_e6", {23'd0, D_n}, 32'h1FE);
    tick(1);
    chk("p9_rel_e7", {23'd0, D_n}, 32'h1FF);
    tick(2);

    // 3. Bounce, then a stable press of key 8.
    for (int i = 0; i < 10; i++) begin
      Y_n = (i % 2 == 0) ? 4'b0111 : 4'b1111;
      tick(1);
      chk("bnc_vld", {31'd0, key_vld}, 32'd0);
      chk("bnc_D_n", {23'd0, D_n}, 32'h1FF);
    end
    tick(4);
    Y_n = 4'b0111;
    sb_q.push_back(4'd8);
    tick(6);
    chk("p8_vld_e6", {31'd0, key_vld}, 32'd0);
    tick(1);
    chk("p8_vld_e7", {31'd0, key_vld}, 32'd1);
    chk("p8_val_e7", {28'd0, key_val}, 32'd8);
    chk("p8_D_n_e7", {23'd0, D_n}, 32'h1FD);
    key_rdy = 1'b1;
    tick(12);
    key_rdy = 1'b0;
    chk("p8_single_vld", {31'd0, key_vld}, 32'd0);
    Y_n = 4'b1111;
    tick(8);
    chk("p8_rel_D_n", {23'd0, D_n}, 32'h1FF);

    // 4. Illegal code 0011 (value 12).
    Y_n = 4'b0011;
    tick(6);
    chk("ill_err_e6", {31'd0, err}, 32'd0);
    tick(1);
    chk("ill_err_e7", {31'd0, err}, 32'd1);
    chk("ill_vld_e7", {31'd0, key_vld}, 32'd0);
    chk("ill_D_n_e7", {23'd0, D_n}, 32'h1FF);
    tick(1);
    chk("ill_err_e8", {31'd0, err}, 32'd0);
    tick(3);
    chk("ill_err_hold", {31'd0, err}, 32'd0);
    Y_n = 4'b1111;
    tick(8);
    chk("ill_rel_D_n", {23'd0, D_n}, 32'h1FF);

    // 5. Overrun, then accept in the same cycle as a confirm.
    Y_n = 4'b1110;
    sb_q.push_back(4'd1);
    tick(7);
    chk("p1_val", {28'd0, key_val}, 32'd1);
    chk("p1_D_n", {23'd0, D_n}, 32'h0FF);
    Y_n = 4'b1111;
    tick(7);
    chk("p1_rel_D_n", {23'd0, D_n}, 32'h1FF);
    Y_n = 4'b1000;
    tick(6);
    chk("ovr_e6", {31'd0, ovr}, 32'd0);
    tick(1);
    chk("ovr_e7", {31'd0, ovr}, 32'd1);
    chk("ovr_val", {28'd0, key_val}, 32'd1);
    chk("ovr_vld", {31'd0, key_vld}, 32'd1);
    chk("ovr_D_n", {23'd0, D_n}, 32'h1FB);
    tick(1);
    chk("ovr_e8", {31'd0, ovr}, 32'd0);
    Y_n = 4'b1111;
    tick(7);
    chk("p7_rel_D_n", {23'd0, D_n}, 32'h1FF);
    Y_n = 4'b1000;
    sb_q.push_back(4'd7);
    tick(6);
    key_rdy = 1'b1;
    tick(1);
    key_rdy = 1'b0;
    chk("same_vld", {31'd0, key_vld}, 32'd1);
    chk("same_val", {28'd0, key_val}, 32'd7);
    chk("same_ovr", {31'd0, ovr}, 32'd0);
    key_rdy = 1'b1;
    tick(1);
    key_rdy = 1'b0;
    chk("same_ack_vld", {31'd0, key_vld}, 32'd0);
    Y_n = 4'b1111;
    tick(8);

    // 6. Asynchronous reset during DEB, and again with a pending report.
    Y_n = 4'b0110;
    tick(4);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_D_n", {23'd0, D_n}, 32'h1FF);
    chk("mid_rst_vld", {31'd0, key_vld}, 32'd0);
    tick(1);
    rst = 1'b0;
    sb_q.push_back(4'd9);
    tick(6);
    chk("rr1_vld_e6", {31'd0, key_vld}, 32'd0);
    tick(1);
    chk("rr1_vld_e7", {31'd0, key_vld}, 32'd1);
    chk("rr1_val_e7", {28'd0, key_val}, 32'd9);
    #2 rst = 1'b1;
    #1;
    chk("vld_rst_vld", {31'd0, key_vld}, 32'd0);
    chk("vld_rst_val", {28'd0, key_val}, 32'd0);
    chk("vld_rst_D_n", {23'd0, D_n}, 32'h1FF);
    sb_q.delete();
    tick(1);
    rst = 1'b0;
    sb_q.push_back(4'd9);
    tick(6);
    chk("rr2_vld_e6", {31'd0, key_vld}, 32'd0);
    tick(1);
    chk("rr2_vld_e7", {31'd0, key_vld}, 32'd1);
    chk("rr2_val_e7", {28'd0, key_val}, 32'd9);
    chk("rr2_D_n_e7", {23'd0, D_n}, 32'h1FE);
    key_rdy = 1'b1;
    tick(1);
    key_rdy = 1'b0;
    Y_n = 4'b1111;
    tick(8);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
